// File: rtl/instruction_issue_unit.sv
// instruction_issue_unit
// Packs five 32-bit host beats into one 156-bit TPU instruction, buffers the
// instructions in a DEPTH-entry FIFO and issues one registered instruction per
// cycle while issue_en is high (all-zero NOP otherwise).
// Optional build macro: INSTR_ISSUE_PARITY_EN -- beat 4 bit 28 carries even
// parity over the 156-bit payload; bad-parity instructions are dropped and
// flagged on parity_err_out.
module instruction_issue_unit #(
    parameter int  DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      host_data_in,
    input  logic             host_valid_in,
    output logic             host_ready_out,
    input  logic             issue_en,
    input  logic             flush,
    output logic [155:0]     instruction,
    output logic             instr_valid_out,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             parity_err_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [2:0]       beat_cnt_r;
    logic [127:0]     shadow_r;
    logic [155:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [155:0]     instruction_r;
    logic             instr_valid_r;

    logic             empty_s;
    logic             full_s;
    logic             ready_s;
    logic             last_beat_s;
    logic             beat_fire_s;
    logic             parity_ok_s;
    logic             push_s;
    logic             pop_s;
    logic [155:0]     word_s;

`ifdef INSTR_ISSUE_PARITY_EN
    // Even parity: payload XOR parity bit must be zero.
    function automatic logic even_parity_ok(input logic [155:0] payload, input logic par_bit);
        return ~((^payload) ^ par_bit);
    endfunction

    logic       parity_err_r;
    logic [2:0] unused_bits_s;
    assign unused_bits_s = host_data_in[31:29];
`else
    logic [3:0] unused_bits_s;
    assign unused_bits_s = host_data_in[31:28];
`endif

    // Handshake, push/pop qualification and the assembled instruction word.
    always_comb begin
        empty_s     = (count_r == CNT_W'(0));
        full_s      = (count_r == CNT_W'(DEPTH));
        last_beat_s = (beat_cnt_r == 3'd4);
        // Backpressure only on the final beat, and only from the registered full flag.
        ready_s     = !last_beat_s || !full_s;
        beat_fire_s = host_valid_in && ready_s && !rst && !flush;
        word_s      = {host_data_in[27:0], shadow_r};
`ifdef INSTR_ISSUE_PARITY_EN
        parity_ok_s = even_parity_ok(word_s, host_data_in[28]);
`else
        parity_ok_s = 1'b1;
`endif
        push_s      = beat_fire_s && last_beat_s && parity_ok_s;
        // Pop decision uses the pre-edge count, so a same-edge push into an empty FIFO is not popped.
        pop_s       = issue_en && !empty_s && !rst && !flush;
    end

    // Packer, FIFO pointers/count and the registered issue stage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            beat_cnt_r    <= 3'd0;
            shadow_r      <= 128'd0;
            wr_ptr_r      <= PTR_W'(0);
            rd_ptr_r      <= PTR_W'(0);
            count_r       <= CNT_W'(0);
            instruction_r <= 156'd0;
            instr_valid_r <= 1'b0;
        end else begin
            if (beat_fire_s) begin
                case (beat_cnt_r)
                    3'd0:    shadow_r[31:0]   <= host_data_in;
                    3'd1:    shadow_r[63:32]  <= host_data_in;
                    3'd2:    shadow_r[95:64]  <= host_data_in;
                    3'd3:    shadow_r[127:96] <= host_data_in;
                    default: shadow_r         <= shadow_r;
                endcase
                beat_cnt_r <= last_beat_s ? 3'd0 : beat_cnt_r + 3'd1;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r      <= rd_ptr_r + PTR_W'(1);
                instruction_r <= mem_r[rd_ptr_r];
                instr_valid_r <= 1'b1;
            end else begin
                instruction_r <= 156'd0;
                instr_valid_r <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

`ifdef INSTR_ISSUE_PARITY_EN
    // One-cycle pulse when a completed instruction is dropped for bad parity.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= beat_fire_s && last_beat_s && !parity_ok_s;
        end
    end
    assign parity_err_out = parity_err_r;
`else
    assign parity_err_out = 1'b0;
`endif

    assign host_ready_out  = ready_s;
    assign instruction     = instruction_r;
    assign instr_valid_out = instr_valid_r;
    assign fifo_count      = count_r;
    assign fifo_empty      = empty_s;
    assign fifo_full       = full_s;

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Scoreboard bench for instruction_issue_unit: stimulus pushes expected
// instructions into a queue, a negedge monitor pops and compares each issue.
module tb_instruction_issue_unit;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      host_data_in = 32'd0;
    logic             host_valid_in = 1'b0;
    logic             host_ready_out;
    logic             issue_en = 1'b0;
    logic             flush = 1'b0;
    logic [155:0]     instruction;
    logic             instr_valid_out;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             parity_err_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [155:0] sb[$];

    instruction_issue_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .host_data_in(host_data_in), .host_valid_in(host_valid_in),
        .host_ready_out(host_ready_out), .issue_en(issue_en), .flush(flush),
        .instruction(instruction), .instr_valid_out(instr_valid_out), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .parity_err_out(parity_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [155:0] act, input logic [155:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] beat_of(input logic [155:0] w, input int i, input logic bad_par);
        logic [31:0] b;
        case (i)
            0:       b = w[31:0];
            1:       b = w[63:32];
            2:       b = w[95:64];
            3:       b = w[127:96];
            default: b = {3'b000, (^w) ^ bad_par, w[155:128]};
        endcase
        return b;
    endfunction

    // Drive one beat from a negedge; returns on the negedge after it is accepted.
    task automatic send_beat(input logic [31:0] d);
        int n = 0;
        host_valid_in = 1'b1;
        host_data_in  = d;
        while (!host_ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 156'd0, 156'd1);
        @(negedge clk);
        host_valid_in = 1'b0;
    endtask

    // Send the first n beats of w; a full 5-beat send is expected in the issue stream.
    task automatic send_partial(input logic [155:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 4) sb.push_back(w);
            send_beat(beat_of(w, i, 1'b0));
        end
    endtask

    task automatic drain();
        int n = 0;
        issue_en = 1'b1;
        while ((sb.size() != 0 || !fifo_empty) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 156'(sb.size()), 156'd0);
        @(negedge clk);
        issue_en = 1'b0;
    endtask

    // Monitor: every issued instruction must match the scoreboard head; otherwise output is NOP.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid_out) begin
                if (sb.size() == 0) chk("unexpected_issue", instruction, 156'd0);
                else chk("issued_word", instruction, sb.pop_front());
            end else begin
                chk("nop_zero", instruction, 156'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [155:0] w;
        logic [155:0] w9;
        bit done;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_instruction", instruction, 156'd0);
        chk("rst_valid", 156'(instr_valid_out), 156'd0);
        chk("rst_ready", 156'(host_ready_out), 156'd1);
        chk("rst_count", 156'(fifo_count), 156'd0);
        chk("rst_empty", 156'(fifo_empty), 156'd1);
        chk("rst_full", 156'(fifo_full), 156'd0);
        chk("rst_parity_err", 156'(parity_err_out), 156'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic issue with exact latency
        issue_en = 1'b1;
        w = {28'h5555555, 128'h44444444_33333333_22222222_11111111};
        chk("basic_b4", 156'(beat_of(w, 4, 1'b0)), 156'h05555555);
        send_partial(w, 5);
        chk("basic_count_after_push", 156'(fifo_count), 156'd1);
        chk("basic_not_yet_valid", 156'(instr_valid_out), 156'd0);
        @(negedge clk);
        chk("basic_valid_t1", 156'(instr_valid_out), 156'd1);
        chk("basic_count_t1", 156'(fifo_count), 156'd0);
        @(negedge clk);
        chk("basic_valid_drop", 156'(instr_valid_out), 156'd0);
        issue_en = 1'b0;

        // Fill and backpressure
        for (int i = 0; i < DEPTH; i++) begin
            w = {28'(32'h0F00000 + i), 32'(i * 7), 32'hA5A50000 + 32'(i), 32'(~i), 32'h100 + 32'(i)};
            send_partial(w, 5);
        end
        chk("fill_count", 156'(fifo_count), 156'(DEPTH));
        chk("fill_full", 156'(fifo_full), 156'd1);
        chk("fill_ready_beat0", 156'(host_ready_out), 156'd1);
        w9 = {28'h9999999, 128'h99990003_99990002_99990001_99990000};
        send_partial(w9, 4);
        sb.push_back(w9);
        host_valid_in = 1'b1;
        host_data_in  = beat_of(w9, 4, 1'b0);
        chk("bp_ready_low", 156'(host_ready_out), 156'd0);
        @(negedge clk);
        chk("bp_ready_still_low", 156'(host_ready_out), 156'd0);
        chk("bp_count_held", 156'(fifo_count), 156'(DEPTH));
        issue_en = 1'b1;
        @(negedge clk);
        issue_en = 1'b0;
        chk("bp_count_after_pop", 156'(fifo_count), 156'(DEPTH - 1));
        chk("bp_ready_high", 156'(host_ready_out), 156'd1);
        @(negedge clk);
        host_valid_in = 1'b0;
        chk("bp_count_refilled", 156'(fifo_count), 156'(DEPTH));
        drain();
        chk("fill_drained_empty", 156'(fifo_empty), 156'd1);

        // Simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++) begin
            w = {28'h3000000 + 28'(i), 128'(32'hB0B0 + i)};
            send_partial(w, 5);
        end
        chk("sim_count3", 156'(fifo_count), 156'd3);
        w = {28'h3000003, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000};
        send_partial(w, 4);
        sb.push_back(w);
        host_valid_in = 1'b1;
        host_data_in  = beat_of(w, 4, 1'b0);
        issue_en      = 1'b1;
        @(negedge clk);
        host_valid_in = 1'b0;
        issue_en      = 1'b0;
        chk("sim_count_unchanged", 156'(fifo_count), 156'd3);
        drain();

        // Flush mid-packing with a queued instruction and a same-cycle beat
        w = {28'h7777777, 128'h77777777_77777777_77777777_77777777};
        send_partial(w, 5);
        w = {28'h6666666, 128'h66666666_66666666_66666666_66666666};
        send_partial(w, 2);
        flush         = 1'b1;
        host_valid_in = 1'b1;
        host_data_in  = 32'hDEADBEEF;
        @(negedge clk);
        flush         = 1'b0;
        host_valid_in = 1'b0;
        sb.delete();
        chk("flush_count", 156'(fifo_count), 156'd0);
        chk("flush_empty", 156'(fifo_empty), 156'd1);
        w = {28'h0ABCDEF, 128'h01234567_89ABCDEF_FEDCBA98_76543210};
        issue_en = 1'b1;
        send_partial(w, 5);
        drain();

        // Wrap-around with random issue_en
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    w = {28'(32'hABC0000 + i), 32'(i * 3), 32'h5A5A0000, 32'hDEAD0000 ^ 32'(i), 32'(i)};
                    send_partial(w, 5);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    issue_en = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        chk("wrap_all_issued", 156'(sb.size()), 156'd0);

`ifdef INSTR_ISSUE_PARITY_EN
        // Parity error drops the instruction; next good one is pushed
        w = {28'h1234567, 128'h0F0F0F0F_12121212_34343434_56565656};
        for (int i = 0; i < 4; i++) send_beat(beat_of(w, i, 1'b0));
        send_beat(beat_of(w, 4, 1'b1));
        chk("par_err_pulse", 156'(parity_err_out), 156'd1);
        chk("par_count_unchanged", 156'(fifo_count), 156'd0);
        @(negedge clk);
        chk("par_err_cleared", 156'(parity_err_out), 156'd0);
        send_partial(w, 5);
        chk("par_good_pushed", 156'(fifo_count), 156'd1);
        drain();
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
